// File: rtl/mult_hilo_if.sv
// mult_hilo_if: bundles the EX-stage request, the Booth-multiplier handshake
// and the HI/LO write port of the multiply controller.
//   slave  modport : the controller (mult_hilo_ctrl)
//   master modport : the pipeline / multiplier side that drives requests,
//                    supplies mul_done/mul_result and consumes HI/LO writes
// Signals:
//   ex_req, ex_op[1:0], ex_op1, ex_op2, hi_i, lo_i, annul  -> controller
//   stallreq                                               <- controller
//   mul_start, mul_op1, mul_op2                            <- controller
//   mul_done, mul_result (signed 64)                       -> controller
//   whi_o, wlo_o, hi_o, lo_o, timeout_o                    <- controller
interface mult_hilo_if;
  logic               ex_req;
  logic [1:0]         ex_op;
  logic [31:0]        ex_op1;
  logic [31:0]        ex_op2;
  logic [31:0]        hi_i;
  logic [31:0]        lo_i;
  logic               annul;
  logic               stallreq;
  logic               mul_start;
  logic [31:0]        mul_op1;
  logic [31:0]        mul_op2;
  logic               mul_done;
  logic signed [63:0] mul_result;
  logic               whi_o;
  logic               wlo_o;
  logic [31:0]        hi_o;
  logic [31:0]        lo_o;
  logic               timeout_o;

  modport slave (
    input  ex_req, ex_op, ex_op1, ex_op2, hi_i, lo_i, annul,
    input  mul_done, mul_result,
    output stallreq, mul_start, mul_op1, mul_op2,
    output whi_o, wlo_o, hi_o, lo_o, timeout_o
  );

  modport master (
    output ex_req, ex_op, ex_op1, ex_op2, hi_i, lo_i, annul,
    output mul_done, mul_result,
    input  stallreq, mul_start, mul_op1, mul_op2,
    input  whi_o, wlo_o, hi_o, lo_o, timeout_o
  );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: sequences a multi-cycle Booth multiplier for the EX stage
// and writes the 64-bit result to HI/LO.
//   clk  : sole clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : mult_hilo_if.slave (request, multiplier handshake, HI/LO write)
// Flow: IDLE -> START -> WAIT (until qualified mul_done or 64-cycle timeout)
//       -> FIX (signed -> unsigned correction / accumulate) -> WRITE -> IDLE.
// Optional feature: define MULT_ACC_EN to enable MADD (ex_op 10) and MSUB
// (ex_op 11). Without it ex_op[1] is ignored and hi_i/lo_i are unused.
module mult_hilo_ctrl (
  input  logic        clk,
  input  logic        rst,
  mult_hilo_if.slave  bus
);

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_FIX   = 3'd3,
    S_WRITE = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [6:0]                cnt_q, cnt_d;
  logic [DATA_W-1:0]         op1_q, op1_d;
  logic [DATA_W-1:0]         op2_q, op2_d;
  logic                      is_u_q, is_u_d;
  logic signed [2*DATA_W-1:0] prod_q, prod_d;
  logic                      timeout_q, timeout_d;
`ifdef MULT_ACC_EN
  logic                      is_madd_q, is_madd_d;
  logic                      is_msub_q, is_msub_d;
  logic [2*DATA_W-1:0]       hilo_q, hilo_d;
`endif

  logic qual_done;
  logic tmo_hit;
  logic accept;

  // The multiplier only drops a stale done once restarted, so the first two
  // WAIT cycles cannot be trusted.
  assign qual_done = bus.mul_done && (cnt_q >= 7'd2);
  // 64th WAIT cycle with no usable done.
  assign tmo_hit   = (state_q == S_WAIT) && !qual_done && (cnt_q == 7'd63);
  assign accept    = (state_q == S_IDLE) && bus.ex_req && !bus.annul;

  // The booth core produces a signed product; for unsigned operands each
  // operand with bit 31 set was read as (x - 2^32), so add the other operand
  // shifted up by 32 to undo it (mod 2^64).
  function automatic logic signed [63:0] multu_fix(
    input logic signed [63:0] p,
    input logic [31:0]        a,
    input logic [31:0]        b
  );
    logic [63:0] r;
    r = p;
    if (a[31]) r = r + {b, 32'b0};
    if (b[31]) r = r + {a, 32'b0};
    return signed'(r);
  endfunction

`ifdef MULT_ACC_EN
  function automatic logic signed [63:0] accumulate(
    input logic [63:0]        hilo,
    input logic signed [63:0] p,
    input logic               sub
  );
    logic [63:0] r;
    r = sub ? (hilo - p) : (hilo + p);
    return signed'(r);
  endfunction
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; annul overrides everything, including done and timeout
  always_comb begin
    state_d = state_q;
    if (bus.annul) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (bus.ex_req) state_d = S_START;
        S_START: state_d = S_WAIT;
        S_WAIT: begin
          if (qual_done)    state_d = S_FIX;
          else if (tmo_hit) state_d = S_IDLE;
        end
        S_FIX:   state_d = S_WRITE;
        S_WRITE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.mul_start = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_FIX);
    bus.mul_op1   = op1_q;
    bus.mul_op2   = op2_q;
    bus.whi_o     = (state_q == S_WRITE) && !bus.annul;
    bus.wlo_o     = (state_q == S_WRITE) && !bus.annul;
    bus.hi_o      = '0;
    bus.lo_o      = '0;
    if ((state_q == S_WRITE) && !bus.annul) begin
      bus.hi_o = prod_q[63:32];
      bus.lo_o = prod_q[31:0];
    end
    // EX is released in the WRITE cycle itself
    bus.stallreq  = bus.ex_req && !bus.annul && (state_q != S_WRITE);
    bus.timeout_o = timeout_q;
  end

  // Datapath next values
  always_comb begin
    op1_d     = op1_q;
    op2_d     = op2_q;
    is_u_d    = is_u_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    timeout_d = tmo_hit && !bus.annul;
`ifdef MULT_ACC_EN
    is_madd_d = is_madd_q;
    is_msub_d = is_msub_q;
    hilo_d    = hilo_q;
`endif
    if (accept) begin
      op1_d = bus.ex_op1;
      op2_d = bus.ex_op2;
`ifdef MULT_ACC_EN
      is_u_d    = (bus.ex_op == 2'b01);
      is_madd_d = (bus.ex_op == 2'b10);
      is_msub_d = (bus.ex_op == 2'b11);
      hilo_d    = {bus.hi_i, bus.lo_i};
`else
      is_u_d = bus.ex_op[0];
`endif
    end
    if (state_q == S_START) cnt_d = '0;
    if (state_q == S_WAIT)  cnt_d = cnt_q + 7'd1;
    if (state_q == S_FIX) begin
      prod_d = bus.mul_result;
      if (is_u_q) prod_d = multu_fix(prod_d, op1_q, op2_q);
`ifdef MULT_ACC_EN
      if (is_madd_q || is_msub_q) prod_d = accumulate(hilo_q, prod_d, is_msub_q);
`endif
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op1_q     <= '0;
      op2_q     <= '0;
      is_u_q    <= 1'b0;
      cnt_q     <= '0;
      prod_q    <= '0;
      timeout_q <= 1'b0;
`ifdef MULT_ACC_EN
      is_madd_q <= 1'b0;
      is_msub_q <= 1'b0;
      hilo_q    <= '0;
`endif
    end else begin
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      is_u_q    <= is_u_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      timeout_q <= timeout_d;
`ifdef MULT_ACC_EN
      is_madd_q <= is_madd_d;
      is_msub_q <= is_msub_d;
      hilo_q    <= hilo_d;
`endif
    end
  end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb_mult_hilo_ctrl: directed vectors for mult_hilo_ctrl with a queue-based
// scoreboard. A behavioural Booth-multiplier responder answers mul_start
// after a configurable number of WAIT cycles, can hold a stale done, or
// never answer.
module tb_mult_hilo_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_hilo_if bus();

  mult_hilo_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit          is_tmo;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Multiplier responder configuration
  int   lat = 2;
  bit   never = 1'b0;
  bit   stale = 1'b0;
  int   run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Responder: run counts cycles of mul_start high; WAIT cycle k sees run=k+1
  always @(posedge clk) begin
    int          rn;
    logic [63:0] pa, pb;
    rn = bus.mul_start ? run + 1 : 0;
    pa = {{32{bus.mul_op1[31]}}, bus.mul_op1};
    pb = {{32{bus.mul_op2[31]}}, bus.mul_op2};
    run <= rn;
    bus.mul_done   <= (!never && rn >= lat + 1) || (stale && (rn == 1 || rn == 2));
    bus.mul_result <= (stale && rn <= 2) ? 64'sd0 : signed'(pa * pb);
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && (bus.whi_o || bus.wlo_o || bus.timeout_o)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {61'd0, bus.whi_o, bus.wlo_o, bus.timeout_o}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        if (e.is_tmo) begin
          chk("tmo_flags", {61'd0, bus.whi_o, bus.wlo_o, bus.timeout_o}, 64'd1);
          chk("tmo_cycle", 64'(cyc), 64'(e.cyc));
        end else begin
          chk("wr_flags", {61'd0, bus.whi_o, bus.wlo_o, bus.timeout_o}, 64'd6);
          chk("wr_hi", {32'd0, bus.hi_o}, {32'd0, e.hi});
          chk("wr_lo", {32'd0, bus.lo_o}, {32'd0, e.lo});
          chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h, input logic [31:0] l,
                        input int lat_i, input bit never_i, input bit stale_i,
                        input bit hold_i, input logic [31:0] eh, input logic [31:0] el);
    exp_t x;
    int   n;
    bit   fin;
    @(posedge clk); #1;
    lat = lat_i; never = never_i; stale = stale_i;
    bus.ex_req = 1'b1; bus.ex_op = op; bus.ex_op1 = a; bus.ex_op2 = b;
    bus.hi_i = h; bus.lo_i = l;
    x.is_tmo = never_i; x.hi = eh; x.lo = el;
    x.cyc = never_i ? cyc + 66 : cyc + 4 + lat_i;
    exp_q.push_back(x);
    if (!hold_i) begin
      repeat (2) @(posedge clk);
      #1 bus.ex_req = 1'b0;
    end
    n = 0; fin = 1'b0;
    while (!fin && n < 300) begin
      @(negedge clk);
      if (bus.whi_o || bus.timeout_o) fin = 1'b1;
      n++;
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s_complete: no write/timeout within 300 cycles", name);
    end
    @(posedge clk); #1;
    bus.ex_req = 1'b0;
    @(negedge clk);
    chk({name, "_idle_start"}, {63'd0, bus.mul_start}, 64'd0);
    chk({name, "_idle_stall"}, {63'd0, bus.stallreq}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ex_req = 1'b0; bus.ex_op = 2'b00; bus.ex_op1 = '0; bus.ex_op2 = '0;
    bus.hi_i = '0; bus.lo_i = '0; bus.annul = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mul_start", {63'd0, bus.mul_start}, 64'd0);
    chk("rst_mul_ops", {bus.mul_op1, bus.mul_op2}, 64'd0);
    chk("rst_write", {62'd0, bus.whi_o, bus.wlo_o}, 64'd0);
    chk("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    chk("rst_timeout", {63'd0, bus.timeout_o}, 64'd0);
    chk("rst_stall_noreq", {63'd0, bus.stallreq}, 64'd0);
    bus.ex_req = 1'b1;
    #1 chk("rst_stall_req", {63'd0, bus.stallreq}, 64'd1);
    bus.ex_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0, 32'h0,
           2, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_big", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 32'h0,
           5, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("multu_both", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
           3, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0,
           4, 1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h0000_0000);
    run_op("mult_stale", 2'b00, 32'h0000_0007, 32'hFFFF_FFFF, 32'h0, 32'h0,
           3, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
`ifdef MULT_ACC_EN
    run_op("madd", 2'b10, 32'd5, 32'd6, 32'h0, 32'h10,
           2, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_002E);
    run_op("msub", 2'b11, 32'd5, 32'd6, 32'h0, 32'h10,
           3, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF2);
`else
    run_op("op10_as_mult", 2'b10, 32'hFFFF_FFFE, 32'h0000_0003, 32'h1234_5678, 32'h9,
           2, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("op11_as_multu", 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'h1234_5678, 32'h9,
           3, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE);
`endif
    run_op("timeout", 2'b00, 32'd3, 32'd4, 32'h0, 32'h0,
           2, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);

    // Annul on the 5th WAIT cycle: no write may follow
    @(posedge clk); #1;
    lat = 20; never = 1'b0; stale = 1'b0;
    bus.ex_req = 1'b1; bus.ex_op = 2'b00; bus.ex_op1 = 32'd3; bus.ex_op2 = 32'd4;
    repeat (6) @(posedge clk);
    #1 bus.annul = 1'b1;
    @(negedge clk);
    chk("annul_wait_start", {63'd0, bus.mul_start}, 64'd1);
    chk("annul_stall_same", {63'd0, bus.stallreq}, 64'd0);
    @(posedge clk); #1;
    bus.annul = 1'b0; bus.ex_req = 1'b0;
    @(negedge clk);
    chk("annul_mul_start", {63'd0, bus.mul_start}, 64'd0);
    chk("annul_stall", {63'd0, bus.stallreq}, 64'd0);
    chk("annul_write", {62'd0, bus.whi_o, bus.wlo_o}, 64'd0);
    repeat (30) @(posedge clk);

    // Reset pulse while in WAIT
    #1;
    lat = 10;
    bus.ex_req = 1'b1; bus.ex_op = 2'b00; bus.ex_op1 = 32'h1234_5678; bus.ex_op2 = 32'd9;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.ex_req = 1'b0;
    @(negedge clk);
    chk("mrst_mul_start", {63'd0, bus.mul_start}, 64'd0);
    chk("mrst_mul_ops", {bus.mul_op1, bus.mul_op2}, 64'd0);
    chk("mrst_write", {62'd0, bus.whi_o, bus.wlo_o}, 64'd0);
    chk("mrst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    chk("mrst_timeout", {63'd0, bus.timeout_o}, 64'd0);
    chk("mrst_stall", {63'd0, bus.stallreq}, 64'd0);
    repeat (15) @(posedge clk);
    run_op("mult_7x7", 2'b00, 32'd7, 32'd7, 32'h0, 32'h0,
           2, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0031);

    repeat (5) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_hilo_ctrl.md
MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: ex_req  in  1  EX stage holds a multiply instruction.
REQ-004 SHALL have: ex_op  in  2  00 MULT, 01 MULTU, 10 MADD, 11 MSUB.
REQ-005 SHALL have: ex_op1, ex_op2  in  32 each  rs/rt operands.
REQ-006 SHALL have: hi_i, lo_i  in  32 each  current HI/LO (forwarded).
REQ-007 SHALL have: annul  in  1  pipeline flush of the EX instruction.
REQ-008 SHALL have: stallreq  out  1  stall request to pipeline control.
REQ-009 SHALL have: mul_start, mul_op1, mul_op2  out  1/32/32  to Booth multiplier.
REQ-010 SHALL have: mul_done  in  1, mul_result  in  64  signed product from multiplier.
REQ-011 SHALL have: whi_o, wlo_o  out  1 each; hi_o, lo_o  out  32 each  HI/LO write port.
REQ-012 SHALL have: timeout_o  out  1  one-cycle pulse on multiplier timeout.

Function
REQ-013 SHALL implement FSM IDLE, START, WAIT, FIX, WRITE; reset state IDLE.
REQ-014 IDLE with ex_req=1: latch ex_op, ex_op1, ex_op2, hi_i, lo_i; go START.
REQ-015 START: mul_start=1; mul_op1/op2 driven from latched operands; go WAIT; cycle counter cleared.
REQ-016 WAIT: mul_start held 1; mul_done ignored while counter<2 (stale done from previous op); first qualified mul_done=1 -> FIX.
REQ-017 WAIT: counter reaching 64 without qualified done -> timeout_o=1 for one cycle, go IDLE, no HI/LO write.
REQ-018 FIX: sample mul_result into 64-bit product P; mul_start=1; go WRITE.
REQ-019 MULTU correction in FIX: P = P + (op1[31]?{op2,32'b0}:0) + (op2[31]?{op1,32'b0}:0), modulo 2^64.
REQ-020 MADD: P = {hi,lo} + P; MSUB: P = {hi,lo} - P; modulo 2^64, signed product (MADDU/MSUBU not supported).
REQ-021 WRITE: whi_o=wlo_o=1, hi_o=P[63:32], lo_o=P[31:0] for exactly one cycle; mul_start=0; go IDLE.
REQ-022 stallreq = ex_req & ~annul & (state != WRITE), combinational; EX advances on the WRITE cycle.
REQ-023 mul_start SHALL be 0 in IDLE and WRITE, guaranteeing >=1 low cycle between operations (restarts multiplier).
REQ-024 Latency: request at IDLE cycle T -> WRITE at T+3+N, N = WAIT cycles until qualified done.
REQ-025 annul=1 in any state: next state IDLE, mul_start=0 next cycle, no write; annul beats mul_done and timeout in the same cycle.
REQ-026 ex_req deasserted mid-operation (without annul) SHALL NOT abort; operation completes and writes.
REQ-027 whi_o, wlo_o, timeout_o SHALL be 0 outside the cases above.

Reset
REQ-028 rst=1 on a clock edge: state IDLE, counter 0, P 0, latched operands 0.
REQ-029 Outputs during/after reset: stallreq 0 unless ex_req (combinational), mul_start 0, whi_o/wlo_o 0, hi_o/lo_o 0, timeout_o 0, mul_op1/op2 0.
REQ-030 rst mid-operation SHALL abandon it with no HI/LO write; rst dominates annul and ex_req.

Configuration
REQ-031 Macro MULT_ACC_EN defined: ex_op 10/11 perform MADD/MSUB per REQ-020.
REQ-032 MULT_ACC_EN undefined: ex_op[1] ignored (10 acts as MULT, 11 as MULTU), hi_i/lo_i unused, no accumulate adder.

Verification
REQ-033 MULT 0xFFFFFFFE x 0x00000003, model returns 0xFFFFFFFF_FFFFFFFA -> single write hi=0xFFFFFFFF lo=0xFFFFFFFA.
REQ-034 MULTU 0xFFFFFFFF x 0x00000002, model returns 0xFFFFFFFF_FFFFFFFE -> hi=0x00000001 lo=0xFFFFFFFE.
REQ-035 MULT_ACC_EN: MADD 5 x 6, hi_i=0, lo_i=0x10 -> hi=0 lo=0x2E; MSUB same -> hi=0xFFFFFFFF lo=0xFFFFFFF2.
REQ-036 annul asserted on 5th WAIT cycle -> next cycle IDLE, mul_start=0, stallreq=0, no whi_o/wlo_o.
REQ-037 Model never raises mul_done -> timeout_o pulse after 64 WAIT cycles, IDLE, no write; mul_done held 1 from prior op in first 2 WAIT cycles -> ignored.
REQ-038 rst pulsed in WAIT -> all outputs at reset values next cycle; following MULT 7x7 writes lo=0x31 hi=0.
